// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the register-mapped SPI master: register map, CTRL fields, FSM states.
package spi_ctrl_pkg;

  localparam logic [7:0] RegAddrBase = 8'h00;
  localparam logic [7:0] RegDataBase = 8'h10;
  localparam logic [7:0] RegCtrl     = 8'h20;
  localparam logic [7:0] RegStatus   = 8'h21;
  localparam logic [7:0] RegRxdBase  = 8'h30;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlNtxLsb   = 1;
  localparam int unsigned CtrlNtxMsb   = 3;
  localparam int unsigned CtrlSsLsb    = 4;
  localparam int unsigned CtrlSsMsb    = 5;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAddr,
    StData,
    StDone
  } state_e;

  // Active-low one-cold chip select for slave index ss.
  function automatic logic [3:0] cs_decode(input logic [1:0] ss);
    cs_decode = ~(4'b0001 << ss);
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SCLK divider and 8-bit LSB-first TX/RX shifter; one bit takes two clocks (low half, high half).
module spi_shift_engine (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       load_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       last_o,
  output logic [7:0] rx_byte_o
);

  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;

  always_comb begin
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    bit_d  = bit_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (load_i) begin
      // Load takes priority so the next byte follows the last bit with no gap.
      tx_d   = tx_byte_i;
      mosi_d = tx_byte_i[0];
      bit_d  = 3'd0;
      sclk_d = 1'b0;
    end else if (run_i) begin
      if (!sclk_q) begin
        sclk_d = 1'b1;
        rx_d   = {miso_i, rx_q[7:1]};
      end else begin
        sclk_d = 1'b0;
        if (bit_q == 3'd7) begin
          mosi_d = 1'b0;
        end else begin
          bit_d  = bit_q + 3'd1;
          mosi_d = tx_q[bit_q + 3'd1];
        end
      end
    end else begin
      sclk_d = 1'b0;
      mosi_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      bit_q  <= 3'd0;
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
    end else begin
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign last_o    = run_i && sclk_q && (bit_q == 3'd7);
  assign rx_byte_o = rx_q;

endmodule

// File: rtl/spi_ctrl.sv
// Register-mapped SPI master: register file, access handshake, burst FSM and persistent slot pointer.
module spi_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned MAX_NUM_TXS = 8,
  parameter int unsigned SETUP_CYC   = 3
) (
  input  logic       pclk_i,
  input  logic       prst_i,
  input  logic [7:0] paddr_i,
  input  logic [7:0] pwdata_i,
  output logic [7:0] prdata_o,
  input  logic       pwrite_i,
  input  logic       penable_i,
  output logic       pready_o,
  input  logic       sclk_ref_i,
  output logic       sclk_o,
  output logic       mosi,
  input  logic       miso,
  output logic [3:0] cs
);

  localparam int unsigned PtrW     = $clog2(MAX_NUM_TXS);
  localparam int unsigned SetupLen = 2 * SETUP_CYC;
  localparam int unsigned CntW     = $clog2(SetupLen + 1);

  logic [7:0]      addr_q [MAX_NUM_TXS];
  logic [7:0]      data_q [MAX_NUM_TXS];
  logic [7:0]      rxd_q  [MAX_NUM_TXS];
  logic [7:1]      ctrl_q;
  state_e          state_q;
  logic [PtrW-1:0] ptr_q;
  logic [PtrW:0]   rem_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      cs_q;
  logic            pready_q, pready_d;
  logic [7:0]      prdata_q, prdata_d;
  logic [7:0]      rdata;

  logic unused_sclk_ref;
  assign unused_sclk_ref = sclk_ref_i;

  logic [PtrW-1:0] idx;
  logic hit_addr, hit_data, hit_rxd, hit_ctrl, hit_status;
  logic busy, stall, acc_done, wr_done, launch;

  assign idx        = paddr_i[PtrW-1:0];
  assign hit_addr   = paddr_i[7:PtrW] == RegAddrBase[7:PtrW];
  assign hit_data   = paddr_i[7:PtrW] == RegDataBase[7:PtrW];
  assign hit_rxd    = paddr_i[7:PtrW] == RegRxdBase[7:PtrW];
  assign hit_ctrl   = paddr_i == RegCtrl;
  assign hit_status = paddr_i == RegStatus;

  assign busy     = state_q != StIdle;
  // CTRL writes wait out a running burst; everything else completes immediately.
  assign stall    = penable_i && pwrite_i && hit_ctrl && busy;
  assign acc_done = penable_i && pready_q;
  assign wr_done  = acc_done && pwrite_i;
  assign launch   = wr_done && hit_ctrl && pwdata_i[CtrlStartBit];

  always_comb begin
    rdata = 8'h00;
    if (hit_addr) begin
      rdata = addr_q[idx];
    end else if (hit_data) begin
      rdata = data_q[idx];
    end else if (hit_rxd) begin
      rdata = rxd_q[idx];
    end else if (hit_ctrl) begin
      rdata = {ctrl_q, 1'b0};
    end else if (hit_status) begin
      rdata = {busy, 7'(ptr_q)};
    end
  end

  always_comb begin
    pready_d = 1'b0;
    prdata_d = 8'h00;
    if (!pready_q && penable_i && !stall) begin
      pready_d = 1'b1;
      prdata_d = pwrite_i ? 8'h00 : rdata;
    end
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      pready_q <= 1'b0;
      prdata_q <= 8'h00;
    end else begin
      pready_q <= pready_d;
      prdata_q <= prdata_d;
    end
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      for (int i = 0; i < MAX_NUM_TXS; i++) begin
        addr_q[i] <= 8'h00;
        data_q[i] <= 8'h00;
      end
      ctrl_q <= '0;
    end else if (wr_done) begin
      if (hit_addr) addr_q[idx] <= pwdata_i;
      if (hit_data) data_q[idx] <= pwdata_i;
      if (hit_ctrl) ctrl_q <= pwdata_i[7:1];
    end
  end

  logic            eng_run, eng_load, eng_last, eng_sclk, eng_mosi;
  logic [7:0]      eng_tx, eng_rx;
  logic            setup_end, last_tx;
  logic [PtrW-1:0] ptr_nxt;

  assign setup_end = (state_q == StSetup) && (cnt_q == CntW'(SetupLen - 1));
  assign last_tx   = rem_q == (PtrW+1)'(1);
  assign ptr_nxt   = ptr_q + PtrW'(1);
  assign eng_run   = state_q inside {StAddr, StData};

  always_comb begin
    eng_load = 1'b0;
    eng_tx   = addr_q[ptr_q];
    case (state_q)
      StSetup: eng_load = setup_end;
      StAddr: begin
        eng_load = eng_last;
        eng_tx   = data_q[ptr_q];
      end
      StData: begin
        eng_load = eng_last && !last_tx;
        eng_tx   = addr_q[ptr_nxt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= 4'hF;
      for (int i = 0; i < MAX_NUM_TXS; i++) rxd_q[i] <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (launch) begin
            state_q <= StSetup;
            cnt_q   <= '0;
            cs_q    <= cs_decode(pwdata_i[CtrlSsMsb:CtrlSsLsb]);
            rem_q   <= (PtrW+1)'(pwdata_i[CtrlNtxMsb:CtrlNtxLsb]) + (PtrW+1)'(1);
          end
        end
        StSetup: begin
          cnt_q <= cnt_q + CntW'(1);
          if (setup_end) state_q <= StAddr;
        end
        StAddr: begin
          if (eng_last) state_q <= StData;
        end
        StData: begin
          if (eng_last) begin
            rxd_q[ptr_q] <= eng_rx;
            ptr_q        <= ptr_nxt;
            if (last_tx) begin
              state_q <= StDone;
              cs_q    <= 4'hF;
            end else begin
              rem_q   <= rem_q - (PtrW+1)'(1);
              state_q <= StAddr;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  spi_shift_engine u_shift (
    .clk_i     (pclk_i),
    .rst_ni    (prst_i),
    .run_i     (eng_run),
    .load_i    (eng_load),
    .tx_byte_i (eng_tx),
    .miso_i    (miso),
    .sclk_o    (eng_sclk),
    .mosi_o    (eng_mosi),
    .last_o    (eng_last),
    .rx_byte_o (eng_rx)
  );

  assign pready_o = pready_q;
  assign prdata_o = prdata_q;
  assign sclk_o   = eng_sclk;
  assign mosi     = eng_mosi;
  assign cs       = cs_q;

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed bench for spi_ctrl: register readback tables, burst byte streams, stall, wrap and reset.
module tb_spi_ctrl;

  logic       pclk_i = 1'b0;
  logic       prst_i;
  logic [7:0] paddr_i, pwdata_i, prdata_o;
  logic       pwrite_i, penable_i, pready_o;
  logic       sclk_ref_i, sclk_o, mosi, miso;
  logic [3:0] cs;

  spi_ctrl dut (
    .pclk_i     (pclk_i),
    .prst_i     (prst_i),
    .paddr_i    (paddr_i),
    .pwdata_i   (pwdata_i),
    .prdata_o   (prdata_o),
    .pwrite_i   (pwrite_i),
    .penable_i  (penable_i),
    .pready_o   (pready_o),
    .sclk_ref_i (sclk_ref_i),
    .sclk_o     (sclk_o),
    .mosi       (mosi),
    .miso       (miso),
    .cs         (cs)
  );

  always #5 pclk_i = ~pclk_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Bus-side SPI monitor and simple slave.
  int         burst_cyc = 0, first_sclk = 0, last_len = 0, bitn = 0, setup_bad = 0, end_bad = 0;
  logic       sclk_prev = 1'b0;
  logic [3:0] cs_seen = 4'hF;
  logic [7:0] cur = 8'h00;
  logic [7:0] byte_q[$];
  logic       use_pat = 1'b0;
  logic [7:0] pat = 8'hB2;

  assign miso = use_pat ? pat[bitn[2:0]] : 1'b1;

  always @(posedge pclk_i) begin
    #1;
    if (cs !== 4'hF) begin
      burst_cyc++;
      if (burst_cyc == 1) first_sclk = 0;
      cs_seen = cs;
      if (burst_cyc <= 6 && (mosi || sclk_o)) setup_bad++;
      if (sclk_o && first_sclk == 0) first_sclk = burst_cyc;
      if (sclk_o && !sclk_prev) begin
        cur = {mosi, cur[7:1]};
        bitn++;
        if (bitn == 8) begin
          byte_q.push_back(cur);
          bitn = 0;
        end
      end
    end else begin
      if (burst_cyc != 0) begin
        last_len = burst_cyc;
        if (mosi || sclk_o) end_bad++;
      end
      burst_cyc = 0;
      bitn = 0;
    end
    sclk_prev = sclk_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                     output logic [7:0] rd, output int waited);
    @(negedge pclk_i);
    paddr_i = a; pwdata_i = wd; pwrite_i = wr; penable_i = 1'b1; waited = 0;
    while (!pready_o && waited < 500) begin
      @(negedge pclk_i);
      waited++;
    end
    rd = prdata_o;
    if (!pready_o) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL apb_timeout addr %0h: pready_o got 0 required 1", a);
    end
    @(posedge pclk_i);
    #1;
    penable_i = 1'b0;
    pwrite_i  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    int w;
    apb(1'b1, a, d, r, w);
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] r;
    int w;
    apb(1'b0, a, 8'h00, r, w);
    check($sformatf("rd_%02h", a), {24'h0, r}, {24'h0, exp});
  endtask

  task automatic wait_idle();
    logic [7:0] s;
    int w;
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      apb(1'b0, 8'h21, 8'h00, s, w);
      if (!s[7]) done = 1'b1;
      else repeat (8) @(negedge pclk_i);
    end
    if (!done) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL busy_timeout: busy got 1 required 0");
    end
  endtask

  // Expected MOSI stream: n slots from start, each ADDR=D3+slot then DATA=46+slot.
  task automatic check_burst(input int start, input int n);
    logic [7:0] act;
    check("mosi_nbytes", byte_q.size(), 2 * n);
    for (int k = 0; k < 2 * n; k++) begin
      int slot = (start + k / 2) % 8;
      act = (k < byte_q.size()) ? byte_q[k] : 8'hxx;
      check($sformatf("mosi_byte%0d", k), {24'h0, act},
            {24'h0, (k % 2 == 0) ? 8'hD3 + 8'(slot) : 8'h46 + 8'(slot)});
    end
  endtask

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[20];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    int w;
    prst_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 8'h00; pwdata_i = 8'h00;
    sclk_ref_i = 1'b0;
    #1 prst_i = 1'b0;
    repeat (3) @(negedge pclk_i);
    check("rst_cs", {28'h0, cs}, 32'hF);
    check("rst_sclk", {31'h0, sclk_o}, 32'h0);
    check("rst_pready", {31'h0, pready_o}, 32'h0);
    check("rst_mosi", {31'h0, mosi}, 32'h0);
    check("rst_prdata", {24'h0, prdata_o}, 32'h0);
    prst_i = 1'b1;
    rd_check(8'h00, 8'h00);
    rd_check(8'h20, 8'h00);
    rd_check(8'h21, 8'h00);

    for (int i = 0; i < 8; i++) begin
      wr(8'(i), 8'hD3 + 8'(i));
      wr(8'h10 + 8'(i), 8'h46 + 8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = {8'(i), 8'hD3 + 8'(i)};
      tbl[8 + i] = {8'h10 + 8'(i), 8'h46 + 8'(i)};
    end
    tbl[16] = {8'h40, 8'h00};
    tbl[17] = {8'h20, 8'h00};
    tbl[18] = {8'h30, 8'h00};
    tbl[19] = {8'h22, 8'h00};
    for (int i = 0; i < 20; i++) rd_check(tbl[i].addr, tbl[i].exp);

    // Three transactions on cs[0] from slot 0.
    byte_q.delete();
    wr(8'h20, 8'h05);
    rd_check(8'h21, 8'h80);
    wait_idle();
    rd_check(8'h21, 8'h03);
    rd_check(8'h20, 8'h04);
    check_burst(0, 3);
    check("burst_len_n3", last_len, 102);
    check("setup_to_first_sclk", first_sclk, 8);
    check("cs_ss0", {28'h0, cs_seen}, 32'hE);

    // Second CTRL write lands while busy and must wait for the first burst to finish.
    byte_q.delete();
    wr(8'h20, 8'h03);
    apb(1'b1, 8'h20, 8'h03, r, w);
    check("stall_wait_window", {31'h0, w >= 70 && w <= 74}, 32'h1);
    check("stall_first_burst_done", byte_q.size(), 4);
    wait_idle();
    rd_check(8'h21, 8'h07);
    check_burst(3, 4);

    for (int i = 0; i < 8; i++) rd_check(8'h30 + 8'(i), (i < 7) ? 8'hFF : 8'h00);

    // Full 8-slot burst from slot 7 wraps through 0..6; slave returns a fixed pattern.
    use_pat = 1'b1;
    byte_q.delete();
    wr(8'h20, 8'h0F);
    wait_idle();
    use_pat = 1'b0;
    check_burst(7, 8);
    check("burst_len_n8", last_len, 262);
    rd_check(8'h21, 8'h07);
    rd_check(8'h20, 8'h0E);
    for (int i = 0; i < 8; i++) rd_check(8'h30 + 8'(i), 8'hB2);
    check("setup_quiet", setup_bad, 0);
    check("done_quiet", end_bad, 0);

    // Reset in the middle of a DATA byte on cs[2].
    wr(8'h20, 8'h21);
    repeat (30) @(negedge pclk_i);
    check("cs_ss2_mid_data", {28'h0, cs}, 32'hB);
    #2 prst_i = 1'b0;
    #1;
    check("midrst_cs", {28'h0, cs}, 32'hF);
    check("midrst_sclk", {31'h0, sclk_o}, 32'h0);
    check("midrst_mosi", {31'h0, mosi}, 32'h0);
    repeat (2) @(negedge pclk_i);
    prst_i = 1'b1;
    rd_check(8'h21, 8'h00);
    rd_check(8'h17, 8'h00);
    rd_check(8'h30, 8'h00);
    rd_check(8'h20, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
